// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the memory-side bus controller
package bus_pkg;

  typedef enum logic [1:0] {
    REG_RAM = 2'd0,
    REG_ROM = 2'd1,
    REG_IO  = 2'd2
  } region_e;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Read data returned to the core when an IO access is abandoned.
  localparam logic [7:0] BUS_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/bus_decode.sv
// rtl/bus_decode.sv - address high byte to region and wait-state count
module bus_decode
  import bus_pkg::*;
#(
  parameter logic [7:0]  IO_PAGE  = 8'hFE,
  parameter logic [7:0]  ROM_BASE = 8'hC0,
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 2
) (
  input  logic [7:0] hi_i,
  output region_e    region_o,
  output logic [3:0] wait_o
);

  // IO page wins over the ROM range even though it sits inside it.
  always_comb begin
    region_o = REG_RAM;
    wait_o   = 4'(RAM_WAIT);
    if (hi_i == IO_PAGE) begin
      region_o = REG_IO;
      wait_o   = 4'(IO_WAIT);
    end else if (hi_i >= ROM_BASE) begin
      region_o = REG_ROM;
      wait_o   = 4'(ROM_WAIT);
    end
  end

endmodule

// File: rtl/bus_wait_ctl.sv
// rtl/bus_wait_ctl.sv - wait-state stretching bus controller with registered read data
module bus_wait_ctl
  import bus_pkg::*;
#(
  parameter logic [7:0]  IO_PAGE  = 8'hFE,
  parameter logic [7:0]  ROM_BASE = 8'hC0,
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned IO_WAIT  = 2,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [15:0] AB,
  input  logic [7:0]  DO,
  input  logic        WE,
  output logic        RDY,
  output logic [7:0]  DI,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        bus_err
);

  localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        we_q, we_d;
  region_e     region_q, region_d;
  logic [7:0]  di_q, di_d;
  logic        err_q, err_d;

  logic [15:0] cur_addr;
  logic [7:0]  cur_wdata;
  logic        cur_we;
  region_e     cur_region;
  region_e     dec_region;
  logic [3:0]  dec_wait;
  logic        done;
  logic        tout;

  // Cycle 0 passes the core's bus straight through; later cycles replay the hold registers.
  assign cur_addr   = (state_q == ST_WAIT) ? addr_q  : AB;
  assign cur_wdata  = (state_q == ST_WAIT) ? wdata_q : DO;
  assign cur_we     = (state_q == ST_WAIT) ? we_q    : WE;
  assign cur_region = (state_q == ST_WAIT) ? region_q : dec_region;

  bus_decode #(
    .IO_PAGE  (IO_PAGE),
    .ROM_BASE (ROM_BASE),
    .RAM_WAIT (RAM_WAIT),
    .ROM_WAIT (ROM_WAIT),
    .IO_WAIT  (IO_WAIT)
  ) u_decode (
    .hi_i     (cur_addr[15:8]),
    .region_o (dec_region),
    .wait_o   (dec_wait)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 16'h0000;
      wdata_q  <= 8'h00;
      we_q     <= 1'b0;
      region_q <= REG_RAM;
      di_q     <= 8'h00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      region_q <= region_d;
      di_q     <= di_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    region_d = region_q;
    done     = 1'b0;
    tout     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (dec_wait == 4'd0 && (cur_region != REG_IO || mem_ack)) begin
          done = 1'b1;
        end else begin
          state_d  = ST_WAIT;
          cnt_d    = 4'd1;
          addr_d   = AB;
          wdata_d  = DO;
          we_d     = WE;
          region_d = dec_region;
        end
      end
      ST_WAIT: begin
        if (cnt_q >= dec_wait && (cur_region != REG_IO || mem_ack)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (cur_region == REG_IO && cnt_q == TIMEOUT_C) begin
          done    = 1'b1;
          tout    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    di_d  = di_q;
    err_d = err_q | tout;
    if (done && !cur_we) begin
      di_d = tout ? BUS_TIMEOUT_DATA : mem_rdata;
    end
  end

  assign RDY       = done & ~RST;
  assign mem_we    = cur_we & done & ~RST;
  assign mem_req   = (cur_region == REG_IO) & ~RST;
  assign mem_addr  = cur_addr;
  assign mem_wdata = cur_wdata;
  assign DI        = di_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_bus_wait_ctl.sv
// tb/tb_bus_wait_ctl.sv - scoreboard bench for bus_wait_ctl against a latency/data model
module tb_bus_wait_ctl;

  localparam logic [7:0] IO_PAGE  = 8'hFE;
  localparam logic [7:0] ROM_BASE = 8'hC0;
  localparam int RAM_WAIT = 0;
  localparam int ROM_WAIT = 1;
  localparam int IO_WAIT  = 2;
  localparam int TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] AB = 16'hFE00;
  logic [7:0]  DO = 8'h00;
  logic        WE = 1'b0;
  logic        RDY;
  logic [7:0]  DI;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack = 1'b1;
  logic [7:0]  mem_rdata = 8'h00;
  logic        bus_err;

  bus_wait_ctl #(
    .IO_PAGE(IO_PAGE), .ROM_BASE(ROM_BASE), .RAM_WAIT(RAM_WAIT),
    .ROM_WAIT(ROM_WAIT), .IO_WAIT(IO_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .RST(RST), .AB(AB), .DO(DO), .WE(WE), .RDY(RDY), .DI(DI),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          done;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  di;
    logic        err;
  } rec_t;

  rec_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic exp_req = 1'b0;
  logic mon_en = 1'b0;
  logic stop = 1'b0;
  logic [7:0] model_di = 8'h00;
  logic       model_err = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_tests = n_tests + 1;
    n_fail = n_fail + 1;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  // Presents one access starting now (posedge+1); returns at posedge+1 of the cycle after completion.
  task automatic run_access(input logic [15:0] a, input logic [7:0] d, input logic w,
                            input logic [15:0] ackm, input logic [7:0] rd);
    logic [7:0] hi;
    logic       io;
    int         ws;
    int         c;
    logic       to;
    rec_t       r;
    hi = a[15:8];
    io = (hi == IO_PAGE);
    ws = io ? IO_WAIT : (hi >= ROM_BASE) ? ROM_WAIT : RAM_WAIT;
    c  = ws;
    to = 1'b0;
    if (io) begin
      c  = TIMEOUT;
      to = 1'b1;
      for (int k = TIMEOUT; k >= IO_WAIT; k--) begin
        if (ackm[k]) begin
          c  = k;
          to = 1'b0;
        end
      end
    end
    if (!w) model_di = to ? 8'hFF : rd;
    model_err = model_err | to;
    r.done = cyc + c; r.addr = a; r.wdata = d; r.we = w; r.di = model_di; r.err = model_err;
    sb.push_back(r);
    for (int k = 0; k <= c; k++) begin
      if (k == 0) begin
        AB = a; DO = d; WE = w;
      end else begin
        AB = 16'($urandom); DO = 8'($urandom); WE = 1'($urandom);
      end
      mem_ack   = ackm[k];
      mem_rdata = (k == c) ? rd : 8'($urandom);
      exp_req   = io;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_random();
    logic [15:0] a;
    logic [15:0] ackm;
    int sel;
    sel = $urandom_range(0, 2);
    if (sel == 0) begin
      a = {8'($urandom_range(0, 8'hBF)), 8'($urandom)};
    end else if (sel == 1) begin
      a[15:8] = 8'($urandom_range(8'hC0, 8'hFE));
      if (a[15:8] == IO_PAGE) a[15:8] = 8'hFF;
      a[7:0] = 8'($urandom);
    end else begin
      a = {IO_PAGE, 8'($urandom)};
    end
    ackm = 16'($urandom);
    if (sel == 2) begin
      ackm = 16'h0000;
      if ($urandom_range(0, 3) != 0) ackm[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 1) != 0) ackm[$urandom_range(0, 1)] = 1'b1;
    end
    run_access(a, 8'($urandom), 1'($urandom), ackm, 8'($urandom));
  endtask

  initial begin
    rec_t pend;
    logic di_pend;
    di_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (di_pend) begin
          chk("di", {24'h0, DI}, {24'h0, pend.di});
          chk("bus_err", {31'h0, bus_err}, {31'h0, pend.err});
          di_pend = 1'b0;
        end
        if (!stop) begin
          chk("mem_req", {31'h0, mem_req}, {31'h0, exp_req});
          if (RDY) begin
            if (sb.size() == 0) begin
              flag("unexpected_rdy");
            end else begin
              pend = sb.pop_front();
              chk("rdy_cycle", cyc, pend.done);
              chk("mem_addr", {16'h0, mem_addr}, {16'h0, pend.addr});
              chk("mem_wdata", {24'h0, mem_wdata}, {24'h0, pend.wdata});
              chk("mem_we", {31'h0, mem_we}, {31'h0, pend.we});
              di_pend = 1'b1;
            end
          end else begin
            if (mem_we) flag("mem_we_without_rdy");
            if (sb.size() > 0 && sb[0].done < cyc) begin
              flag("missed_rdy");
              void'(sb.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    chk("rst_rdy", {31'h0, RDY}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_di", {24'h0, DI}, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    @(posedge clk); #1;
    RST = 1'b0;
    mon_en = 1'b1;

    run_access(16'h0200, 8'h00, 1'b0, 16'h0000, 8'h5A);
    run_access(16'hFFFC, 8'h00, 1'b0, 16'hFFFF, 8'($urandom));
    run_access(16'hFE10, 8'h33, 1'b1, 16'h0010, 8'($urandom));
    run_access(16'hFE44, 8'h00, 1'b0, 16'h000A, 8'hC3);
    run_access(16'hFE00, 8'h00, 1'b0, 16'h0000, 8'h12);
    for (int i = 0; i < 200; i++) run_random();

    // Ensure bus_err is set, then abort an IO write mid-wait with reset.
    run_access(16'hFE00, 8'h00, 1'b1, 16'h0000, 8'h00);
    AB = 16'hFE20; DO = 8'h77; WE = 1'b1; mem_ack = 1'b0; exp_req = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    RST = 1'b1; mem_ack = 1'b1; exp_req = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    RST = 1'b0;
    model_di = 8'h00;
    model_err = 1'b0;
    run_access(16'h0200, 8'h00, 1'b0, 16'h0000, 8'hA5);
    for (int i = 0; i < 40; i++) run_random();

    stop = 1'b1;
    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
